alu_seq: RTL and testbench

// - Sequential successor to the combinational datapath ALU: width-generic, with a valid/ready handshake on both sides.
// - Adds a multi-cycle shift-add signed fixed-point multiplier (no hard multiplier), SUB, an overflow flag and optional saturation.
// - Sits between the decode stage and the register-file writeback; the control FSM stalls while out_valid is low.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_seq_shift_add_mul.sv | 47 ++++
 rtl/alu_seq.sv | 126 ++++++++++++
 tb/tb_alu_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: function codes and control FSM states.
// ALU_A, ALU_B and ALU_ADD keep their original encodings.
package alu_seq_pkg;

  localparam int FUNC_W = 3;

  typedef enum logic [FUNC_W-1:0] {
    ALU_A   = 3'd0,
    ALU_B   = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_MUL = 3'd4
  } aluFunc_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIX,
    DONE
  } alu_state_t;

endpackage

// File: rtl/alu_seq_shift_add_mul.sv
// Unsigned magnitude shift-add multiplier: one multiplier bit per clock, LSB first.
// done is high during the edge that retires the last bit.
module shift_add_mul #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     mcand_in,
  input  logic [N-1:0]     mplier_in,
  output logic [2*N-1:0]   acc,
  output logic             busy,
  output logic             done
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [CW-1:0] cnt;

  assign done = busy && (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[cnt[IW-1:0]])
        acc <= acc + ({{N{1'b0}}, mcand} << cnt);
      cnt <= cnt + CW'(1);
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle A/B/ADD/SUB and a
// multi-cycle signed fixed-point multiply built on an unsigned shift-add core.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N    = 8,
  parameter int FRAC = N - 1,
  parameter int SAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic [FUNC_W-1:0]   func,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] result,
  output logic                overflow
);

  localparam int HW = N - FRAC + 1;

  alu_state_t state, state_n;

  logic                  accept;
  logic                  mul_start;
  logic [N-1:0]          mag_a;
  logic [N-1:0]          mag_b;
  logic                  neg;
  logic [2*N-1:0]        acc;
  logic                  mul_busy;
  logic                  mul_done;
  logic signed [N:0]     sum_ext;
  logic signed [N-1:0]   alu_res;
  logic                  alu_ovf;
  logic signed [2*N-1:0] p;
  logic [HW-1:0]         hi;
  logic signed [N-1:0]   mul_res;
  logic                  mul_ovf;

  function automatic logic signed [N-1:0] sat_clamp(input logic to_neg);
    return to_neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (func == ALU_MUL);
  assign mag_a     = a[N-1] ? -a : a;
  assign mag_b     = b[N-1] ? -b : b;

  shift_add_mul #(.N(N)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (mul_start),
    .mcand_in  (mag_a),
    .mplier_in (mag_b),
    .acc       (acc),
    .busy      (mul_busy),
    .done      (mul_done)
  );

  always_comb begin
    sum_ext = (func == ALU_SUB) ? ({a[N-1], a} - {b[N-1], b})
                                : ({a[N-1], a} + {b[N-1], b});
    alu_res = a;
    alu_ovf = 1'b0;
    case (func)
      ALU_B: alu_res = b;
      ALU_ADD, ALU_SUB: begin
        alu_ovf = sum_ext[N] ^ sum_ext[N-1];
        alu_res = (alu_ovf && SAT != 0) ? sat_clamp(sum_ext[N]) : sum_ext[N-1:0];
      end
      default: ;
    endcase
  end

  // Sign restore and fixed-point slice: the product fits when every bit above
  // the result's sign position matches it.
  always_comb begin
    p       = neg ? -$signed(acc) : $signed(acc);
    hi      = HW'(p >>> (FRAC + N - 1));
    mul_ovf = (|hi) && !(&hi);
    mul_res = mul_ovf && SAT != 0 ? sat_clamp(p[2*N-1]) : N'(p >>> FRAC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = (func == ALU_MUL) ? MUL : DONE;
      MUL:  if (mul_done || !mul_busy) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      overflow <= 1'b0;
      neg      <= 1'b0;
    end else begin
      if (accept && func != ALU_MUL) begin
        result   <= alu_res;
        overflow <= alu_ovf;
      end
      if (mul_start)
        neg <= a[N-1] ^ b[N-1];
      if (state == FIX) begin
        result   <= mul_res;
        overflow <= mul_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors plus randomized traffic
// on an 8-bit lane (four FRAC/SAT variants) and a 16-bit lane (two variants).
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [2:0]  func = '0;
  logic        iv8 = 1'b0, iv16 = 1'b0, ordy = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;

  logic        ir8[4], ov8[4], of8[4];
  logic [7:0]  r8[4];
  logic        ir16[2], ov16[2], of16[2];
  logic [15:0] r16[2];

  localparam int F8[4]  = '{7, 7, 0, 3};
  localparam int S8[4]  = '{1, 0, 1, 0};
  localparam int F16[2] = '{9, 15};
  localparam int S16[2] = '{1, 0};

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  excl_en  = 1'b0;

  alu_seq #(.N(8), .FRAC(F8[0]), .SAT(S8[0])) u8_0 (.clk(clk), .reset(reset), .in_valid(iv8),
    .in_ready(ir8[0]), .a(a8), .b(b8), .func(func), .out_valid(ov8[0]), .out_ready(ordy),
    .result(r8[0]), .overflow(of8[0]));
  alu_seq #(.N(8), .FRAC(F8[1]), .SAT(S8[1])) u8_1 (.clk(clk), .reset(reset), .in_valid(iv8),
    .in_ready(ir8[1]), .a(a8), .b(b8), .func(func), .out_valid(ov8[1]), .out_ready(ordy),
    .result(r8[1]), .overflow(of8[1]));
  alu_seq #(.N(8), .FRAC(F8[2]), .SAT(S8[2])) u8_2 (.clk(clk), .reset(reset), .in_valid(iv8),
    .in_ready(ir8[2]), .a(a8), .b(b8), .func(func), .out_valid(ov8[2]), .out_ready(ordy),
    .result(r8[2]), .overflow(of8[2]));
  alu_seq #(.N(8), .FRAC(F8[3]), .SAT(S8[3])) u8_3 (.clk(clk), .reset(reset), .in_valid(iv8),
    .in_ready(ir8[3]), .a(a8), .b(b8), .func(func), .out_valid(ov8[3]), .out_ready(ordy),
    .result(r8[3]), .overflow(of8[3]));
  alu_seq #(.N(16), .FRAC(F16[0]), .SAT(S16[0])) u16_0 (.clk(clk), .reset(reset), .in_valid(iv16),
    .in_ready(ir16[0]), .a(a16), .b(b16), .func(func), .out_valid(ov16[0]), .out_ready(ordy),
    .result(r16[0]), .overflow(of16[0]));
  alu_seq #(.N(16), .FRAC(F16[1]), .SAT(S16[1])) u16_1 (.clk(clk), .reset(reset), .in_valid(iv16),
    .in_ready(ir16[1]), .a(a16), .b(b16), .func(func), .out_valid(ov16[1]), .out_ready(ordy),
    .result(r16[1]), .overflow(of16[1]));

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Sign-interpret the low n bits of v.
  function automatic longint sx(input longint v, input int n);
    longint m, w;
    m = longint'(1) << n;
    w = v & (m - 1);
    if (w >= (m >>> 1)) w = w - m;
    return w;
  endfunction

  // Reference: exact integer arithmetic, then range test against n-bit signed.
  function automatic void model(input int n, input int frac, input int sat,
                                input logic [2:0] f, input longint ar, input longint br,
                                output longint r, output bit o);
    longint av, bv, mx, mn, t;
    av = sx(ar, n);
    bv = sx(br, n);
    mx = (longint'(1) << (n - 1)) - 1;
    mn = -(longint'(1) << (n - 1));
    case (f)
      ALU_B:   t = bv;
      ALU_ADD: t = av + bv;
      ALU_SUB: t = av - bv;
      ALU_MUL: t = (av * bv) >>> frac;
      default: t = av;
    endcase
    o = (t > mx) || (t < mn);
    if (!o)          r = t;
    else if (sat!=0) r = (t < 0) ? mn : mx;
    else             r = sx(t, n);
  endfunction

  function automatic int ndut(input int l);   return (l == 0) ? 4 : 2; endfunction
  function automatic int nbits(input int l);  return (l == 0) ? 8 : 16; endfunction
  function automatic int lfrac(input int l, input int k); return (l == 0) ? F8[k] : F16[k]; endfunction
  function automatic int lsat(input int l, input int k);  return (l == 0) ? S8[k] : S16[k]; endfunction
  function automatic logic lrdy(input int l, input int k); return (l == 0) ? ir8[k] : ir16[k]; endfunction
  function automatic logic lval(input int l, input int k); return (l == 0) ? ov8[k] : ov16[k]; endfunction
  function automatic logic lovf(input int l, input int k); return (l == 0) ? of8[k] : of16[k]; endfunction
  function automatic longint lres(input int l, input int k);
    return (l == 0) ? longint'($signed(r8[k])) : longint'($signed(r16[k]));
  endfunction

  always @(negedge clk) begin
    if (excl_en) begin
      logic both;
      both = 1'b0;
      for (int k = 0; k < 4; k++) both = both | (ir8[k] & ov8[k]);
      for (int k = 0; k < 2; k++) both = both | (ir16[k] & ov16[k]);
      check("ready_valid_excl", both, 0);
    end
  end

  task automatic do_op(input int l, input logic [2:0] f, input longint av,
                       input longint bv, input int hold, input string tag);
    int lat, n;
    longint er, snap[4];
    bit eo;
    n = nbits(l);
    @(negedge clk);
    check({tag, ".in_ready"}, lrdy(l, 0), 1);
    func = f;
    if (l == 0) begin a8 = av[7:0];  b8 = bv[7:0];  iv8 = 1'b1; end
    else        begin a16 = av[15:0]; b16 = bv[15:0]; iv16 = 1'b1; end
    @(posedge clk); #1;
    lat = 1;
    iv8 = 1'b0; iv16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); func = 3'($urandom);
    while (!lval(l, 0) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, (f == ALU_MUL) ? n + 2 : 1);
    for (int k = 0; k < ndut(l); k++) begin
      model(n, lfrac(l, k), lsat(l, k), f, av, bv, er, eo);
      check({tag, ".out_valid"}, lval(l, k), 1);
      check({tag, ".result"}, lres(l, k), er);
      check({tag, ".overflow"}, lovf(l, k), eo);
      snap[k] = lres(l, k);
    end
    repeat (hold) begin
      @(posedge clk); #1;
      for (int k = 0; k < ndut(l); k++) begin
        check({tag, ".hold_result"}, lres(l, k), snap[k]);
        check({tag, ".hold_valid"}, lval(l, k), 1);
        check({tag, ".hold_in_ready"}, lrdy(l, k), 0);
      end
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check({tag, ".release_valid"}, lval(l, 0), 0);
    check({tag, ".release_ready"}, lrdy(l, 0), 1);
  endtask

  initial begin
    logic [2:0] f;
    // Reset held three cycles.
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rst.result", lres(0, k), 0);
      check("rst.overflow", of8[k], 0);
      check("rst.out_valid", ov8[k], 0);
      check("rst.in_ready", ir8[k], 1);
    end
    check("rst16.result", lres(1, 0), 0);
    check("rst16.in_ready", ir16[0], 1);
    @(negedge clk);
    reset = 1'b0;
    excl_en = 1'b1;

    do_op(0, ALU_ADD, 100, 50, 5, "add_sat");
    check("add_sat.sat1", lres(0, 0), 127);
    check("add_sat.sat0", lres(0, 1), -106);
    check("add_sat.ovf", of8[1], 1);
    do_op(0, ALU_SUB, 5, 7, 0, "sub");
    check("sub.value", lres(0, 0), -2);
    check("sub.ovf", of8[0], 0);
    do_op(0, ALU_MUL, 'h40, 'h40, 2, "mul_half");
    check("mul_half.value", lres(0, 0), 'sh20);
    do_op(0, ALU_MUL, 'h40, 'hC0, 0, "mul_neg");
    check("mul_neg.value", lres(0, 0), -32);
    do_op(0, ALU_MUL, 'h80, 'h80, 1, "mul_min");
    check("mul_min.sat1", lres(0, 0), 127);
    check("mul_min.sat0", lres(0, 1), -128);
    check("mul_min.ovf", of8[0], 1);
    do_op(0, ALU_A, 'h55, 'h22, 0, "pass_a");
    do_op(0, ALU_B, 'h55, 'h22, 0, "pass_b");
    do_op(0, 3'd7, 'h91, 'h22, 0, "undef");

    // Asynchronous reset during the fourth multiplier iteration.
    @(negedge clk);
    func = ALU_MUL; a8 = 8'h7F; b8 = 8'h81; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    excl_en = 1'b0;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("midrst.result", lres(0, k), 0);
      check("midrst.overflow", of8[k], 0);
      check("midrst.out_valid", ov8[k], 0);
      check("midrst.in_ready", ir8[k], 1);
    end
    @(negedge clk);
    reset = 1'b0;
    excl_en = 1'b1;
    do_op(0, ALU_MUL, 3, -2, 0, "after_rst");
    check("after_rst.frac0", lres(0, 2), -6);

    for (int i = 0; i < 2500; i++) begin
      f = ($urandom_range(0, 1) != 0) ? 3'(ALU_MUL) : 3'($urandom_range(0, 7));
      do_op(0, f, longint'($urandom), longint'($urandom), $urandom_range(0, 3), "rnd8");
    end
    for (int i = 0; i < 1000; i++) begin
      f = ($urandom_range(0, 1) != 0) ? 3'(ALU_MUL) : 3'($urandom_range(0, 7));
      do_op(1, f, longint'($urandom), longint'($urandom), $urandom_range(0, 3), "rnd16");
    end

    excl_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
